// File: rtl/psel_gen.sv
// psel_gen: registered parallel priority selector.
// Picks up to REQS distinct set bits of req, one per grant lane. By default even lanes take
// the lowest remaining set bit and odd lanes the highest. Defining PSEL_GEN_LSB_ORDER_EN makes
// every lane take the lowest remaining bit instead.
module psel_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned REQS  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           req,
    output logic [WIDTH-1:0]           gnt,
    output logic [REQS-1:0][WIDTH-1:0] gnt_bus,
    output logic                       empty
);

`ifdef PSEL_GEN_LSB_ORDER_EN
    localparam bit LsbOrder = 1'b1;
`else
    localparam bit LsbOrder = 1'b0;
`endif

    // One-hot of the lowest set bit, zero if none.
    function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // One-hot of the highest set bit, zero if none.
    function automatic logic [WIDTH-1:0] highest_bit(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [REQS-1:0][WIDTH-1:0] w_lane;
    logic [WIDTH-1:0]           w_avail;
    logic [WIDTH-1:0]           w_gnt;

    logic [REQS-1:0][WIDTH-1:0] r_gnt_bus;
    logic [WIDTH-1:0]           r_gnt;
    logic                       r_empty;

    // Resolve lanes in index order, masking off bits already taken by lower lanes.
    always_comb begin
        w_lane  = '0;
        w_gnt   = '0;
        w_avail = req;
        for (int k = 0; k < int'(REQS); k++) begin
            if (LsbOrder || ((k % 2) == 0)) begin
                w_lane[k] = lowest_bit(w_avail);
            end else begin
                w_lane[k] = highest_bit(w_avail);
            end
            w_avail = w_avail & ~w_lane[k];
            w_gnt   = w_gnt | w_lane[k];
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt_bus <= '0;
            r_gnt     <= '0;
            r_empty   <= 1'b1;
        end else begin
            r_gnt_bus <= w_lane;
            r_gnt     <= w_gnt;
            r_empty   <= (req == '0);
        end
    end

    assign gnt_bus = r_gnt_bus;
    assign gnt     = r_gnt;
    assign empty   = r_empty;

endmodule

// File: tb/tb_psel_gen.sv
// Scoreboard bench for psel_gen. Honours PSEL_GEN_LSB_ORDER_EN for the reference ordering.
module tb_psel_gen;

    localparam int WIDTH = 16;
    localparam int REQS  = 4;

`ifdef PSEL_GEN_LSB_ORDER_EN
    localparam bit LsbOrder = 1'b1;
`else
    localparam bit LsbOrder = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0]           req;
        logic [REQS-1:0][WIDTH-1:0] bus;
        logic [WIDTH-1:0]           gnt;
        logic                       empty;
        logic                       rst;
    } exp_t;

    logic                       clock;
    logic                       reset;
    logic [WIDTH-1:0]           req;
    logic [WIDTH-1:0]           gnt;
    logic [REQS-1:0][WIDTH-1:0] gnt_bus;
    logic                       empty;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    psel_gen #(
        .WIDTH (WIDTH),
        .REQS  (REQS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_bus (gnt_bus),
        .empty   (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: list the set-bit positions, then deal them out front/back per lane.
    function automatic exp_t model(input logic [WIDTH-1:0] r, input logic rst);
        exp_t e;
        int   idx[$];
        int   pick;
        e.req   = r;
        e.rst   = rst;
        e.bus   = '0;
        e.gnt   = '0;
        e.empty = 1'b1;
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r[i]) idx.push_back(i);
            end
            e.empty = (idx.size() == 0);
            for (int k = 0; k < REQS; k++) begin
                if (idx.size() == 0) break;
                if (LsbOrder || (k % 2 == 0)) pick = idx.pop_front();
                else pick = idx.pop_back();
                e.bus[k][pick] = 1'b1;
                e.gnt[pick]    = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v,
                         input logic [WIDTH-1:0] r);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s req=%h actual=%h expected=%h", name, r, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected response.
    task automatic drive(input logic [WIDTH-1:0] r, input logic rst);
        @(negedge clock);
        req   = r;
        reset = rst;
        sb_q.push_back(model(r, rst));
    endtask

    // Monitor: every cycle the registered outputs are compared with the oldest expectation.
    always @(posedge clock) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            int   pc_req;
            int   pc_gnt;
            int   lim;
            e = sb_q.pop_front();
            for (int k = 0; k < REQS; k++) begin
                check($sformatf("lane%0d", k), 64'(gnt_bus[k]), 64'(e.bus[k]), e.req);
            end
            check("gnt", 64'(gnt), 64'(e.gnt), e.req);
            check("empty", 64'(empty), 64'(e.empty), e.req);
            if (!e.rst) begin
                pc_req = $countones(e.req);
                pc_gnt = $countones(gnt);
                lim    = (pc_req < REQS) ? pc_req : REQS;
                check("popcount", 64'(pc_gnt), 64'(lim), e.req);
                check("subset", 64'(gnt & ~e.req), 64'(0), e.req);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] r;
        int               waited;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        req      = '1;
        drive(16'hFFFF, 1'b1);
        drive(16'hFFFF, 1'b1);
        drive(16'hFFFF, 1'b0);
        drive(16'h0000, 1'b0);
        drive(16'h0010, 1'b0);
        drive(16'h0104, 1'b0);
        drive(16'h0F00, 1'b0);
        drive(16'h8001, 1'b0);
        drive(16'hFFFF, 1'b0);
        drive(16'hA5A5, 1'b1);   // reset mid-run wins over req
        drive(16'h0001, 1'b0);
        drive(16'h8000, 1'b0);
        drive(16'h0007, 1'b0);
        for (int n = 0; n < 160; n++) begin
            case (n % 4)
                0: r = WIDTH'($urandom);
                1: r = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
                2: r = WIDTH'(1) << $urandom_range(WIDTH - 1, 0);
                default: r = WIDTH'($urandom) | WIDTH'($urandom);
            endcase
            drive(r, ($urandom_range(39, 0) == 0));
        end
        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        @(negedge clock);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/psel_gen.md
Name: psel_gen

Overview:
Parallel priority selector. Picks up to REQS distinct set bits from a WIDTH-bit free/request vector, one per grant lane, alternating from the low end and the high end. Used to allocate multiple free entries per cycle, e.g. ROB, RS or free-list slots for a superscalar dispatch stage. Outputs are registered.

Parameters:
- WIDTH, 16, number of request/free bits; must be >= 1.
- REQS, 4, number of grant lanes (grants per cycle); must be >= 1. Lanes beyond the number of set bits are zero.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  WIDTH  request/free vector; bit i=1 means entry i is available.
- gnt  output  WIDTH  OR of all gnt_bus lanes; registered.
- gnt_bus  output  REQS x WIDTH (packed [REQS-1:0][WIDTH-1:0])  per-lane one-hot or zero grant; registered.
- empty  output  1  high when req had no set bit; registered.

Behaviour:
- Reset is synchronous, active-high, sampled on the rising clock edge:
  - gnt = 0
  - all gnt_bus lanes = 0
  - empty = 1
- Reset has priority over any req value, including mid-operation. The cycle after reset is deasserted reflects the req sampled at that edge.
- Latency: fixed 1 cycle. Outputs at edge n+1 are a pure function of req sampled at edge n. There is no other state and no handshake; req is sampled every cycle.
- Lane assignment (default ordering):
  - Even lanes 0, 2, 4, … take the lowest, 2nd-lowest, 3rd-lowest … set bit.
  - Odd lanes 1, 3, 5, … take the highest, 2nd-highest … set bit.
  - Lanes are resolved in index order, skipping bits already granted to a lower-index lane.
- Each gnt_bus lane is either one-hot or all-zero.
- No bit is granted to two lanes; lanes are pairwise disjoint.
- If popcount(req) < REQS, lanes numbered popcount(req) and above are zero. Lower lanes remain valid under the ordering rule.
  - Example: a single set bit goes to lane 0 only; lane 1 = 0.
- gnt = bitwise OR of all lanes. popcount(gnt) = min(popcount(req), REQS), and gnt is a subset of req.
- empty = (req == 0). When empty = 1, gnt and all lanes are 0.
- REQS > WIDTH is legal; lanes beyond WIDTH are always 0.
- No X propagation from unused lanes: every lane drives 0 when not granting.
- Next-state logic must be synthesizable combinational logic: generate/for loops with masked priority encoders, no latches.

Optional Feature:
- Macro: PSEL_GEN_LSB_ORDER_EN.
- Defined: all lanes allocate strictly ascending from the LSB; lane k = k-th lowest set bit (k = 0-based).
  - req=16'hFFFF, REQS=4 → lanes 0001, 0002, 0004, 0008.
- Undefined (default): alternating low/high ordering as in Behaviour.
- Latency, reset values, gnt and empty semantics are identical in both builds.

Test Plan (WIDTH=16, REQS=4; each check one cycle after req applied):
- Reset held with req=16'hFFFF → gnt=0000, all lanes 0000, empty=1. Release reset → next cycle matches the 16'hFFFF case below.
- req=16'hFFFF → lane0=0001, lane1=8000, lane2=0002, lane3=4000; gnt=C003; empty=0.
- req=16'h0000 → all lanes 0000, gnt=0000, empty=1.
- req=16'h0010 → lane0=0010, lanes1-3=0000, gnt=0010, empty=0. Then req=16'h0104 → lane0=0004, lane1=0100, lanes2-3=0000, gnt=0104.
- req=16'h0F00 → lane0=0100, lane1=0800, lane2=0200, lane3=0400, gnt=0F00. Back-to-back change to 16'h8001 next cycle → lane0=0001, lane1=8000, lanes2-3=0, gnt=8001.
- Random req, 100+ cycles → lanes one-hot or zero and pairwise disjoint, gnt ⊆ req, popcount(gnt)=min(popcount(req),4), empty==(req==0). Repeat with PSEL_GEN_LSB_ORDER_EN defined: 16'hFFFF → 0001/0002/0004/0008.
